// File: rtl/pattern_pkg.sv
// Shared definitions for the test-pattern generator and checker:
// mode encodings, line lengths, ramp delta decode tables and FSM states.
package pattern_pkg;

  localparam int PIX_W   = 12;
  localparam int LEN_STD = 1290;
  localparam int LEN_REG = 4096;

  typedef enum logic [2:0] {
    MODE_NONE     = 3'b000,
    MODE_REGULAR  = 3'b001,
    MODE_CONST    = 3'b010,
    MODE_WHITE1X1 = 3'b011,
    MODE_BLACK1X1 = 3'b100,
    MODE_WHITE2X2 = 3'b101,
    MODE_BLACK2X2 = 3'b110,
    MODE_RAMP     = 3'b111
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAT,
    ST_CHECK,
    ST_GAP
  } state_t;

  // Per-pixel ramp increment selected by the X code.
  function automatic logic [PIX_W-1:0] dx_decode(input logic [1:0] code);
    case (code)
      2'b00:   return 12'd0;
      2'b01:   return 12'd1;
      2'b10:   return 12'd4;
      default: return 12'd8;
    endcase
  endfunction

  // Per-line ramp increment selected by the Y code.
  function automatic logic [PIX_W-1:0] dy_decode(input logic [1:0] code);
    case (code)
      2'b00:   return 12'd0;
      2'b01:   return 12'd1;
      2'b10:   return 12'd16;
      default: return 12'd1290;
    endcase
  endfunction

  // Index of the last pixel of a line for the given mode.
  function automatic logic [PIX_W-1:0] line_last(input mode_t m);
    return (m == MODE_REGULAR) ? 12'(LEN_REG - 1) : 12'(LEN_STD - 1);
  endfunction

endpackage

// File: rtl/pattern_expect.sv
// Expected-pixel engine: latches the frame parameters on frame start and
// keeps the pixel index and ramp accumulators (no multiplier needed).
module pattern_expect
  import pattern_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             line_start,
  input  logic             pix_adv,
  input  logic [2:0]       mode,
  input  logic [PIX_W-1:0] const_val,
  input  logic [1:0]       x,
  input  logic [1:0]       y,
  input  logic [1:0]       line_lsb,
  output logic [PIX_W-1:0] expected,
  output logic             last_pix,
  output logic             mode_valid
);

  mode_t            mode_q;
  logic [PIX_W-1:0] const_q;
  logic [PIX_W-1:0] dx_q;
  logic [PIX_W-1:0] dy_q;
  logic [PIX_W-1:0] pix_q;
  logic [PIX_W-1:0] base_q;
  logic [PIX_W-1:0] ramp_q;
  logic             chk1;
  logic             chk2;

  // Latch parameters per frame; step line base by dY and pixel ramp by dX.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    if (!rst_n) begin
      mode_q  <= MODE_NONE;
      const_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      pix_q   <= '0;
      base_q  <= '0;
      ramp_q  <= '0;
    end else if (frame_start) begin
      mode_q  <= mode_t'(mode);
      const_q <= const_val;
      dx_q    <= dx_decode(x);
      dy_q    <= dy_decode(y);
      pix_q   <= '0;
      base_q  <= '0;
      ramp_q  <= '0;
    end else if (line_start) begin
      pix_q   <= '0;
      base_q  <= base_q + dy_q;
      ramp_q  <= base_q + dy_q;
    end else if (pix_adv) begin
      pix_q   <= pix_q + 12'd1;
      ramp_q  <= ramp_q + dx_q;
    end
  end

  assign chk1 = pix_q[0] ^ line_lsb[0];
  assign chk2 = pix_q[1] ^ line_lsb[1];

  // Decode the expected pixel for the current line and pixel position.
  always_comb begin
    // NOTE: default assignment first so every path drives expected; no latch.
    expected = '0;
    case (mode_q)
      MODE_REGULAR:  expected = pix_q ^ (pix_q >> 1);
      MODE_CONST:    expected = const_q;
      MODE_WHITE1X1: expected = {PIX_W{chk1}};
      MODE_BLACK1X1: expected = {PIX_W{~chk1}};
      MODE_WHITE2X2: expected = {PIX_W{chk2}};
      MODE_BLACK2X2: expected = {PIX_W{~chk2}};
      MODE_RAMP:     expected = ramp_q;
      default:       expected = '0;
    endcase
  end

  assign last_pix   = (pix_q == line_last(mode_q));
  assign mode_valid = (mode_q != MODE_NONE);

endmodule

// File: rtl/pattern_checker.sv
// Receive-side pattern checker: tracks line/pixel timing from sync, compares
// each pixel against pattern_expect, counts mismatches and short lines.
module pattern_checker
  import pattern_pkg::*;
#(
  parameter int SYNC_LAT = 3,
  parameter int LINES    = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_sync,
  input  logic             sync,
  input  logic [2:0]       Mode,
  input  logic [PIX_W-1:0] constVal,
  input  logic [1:0]       X,
  input  logic [1:0]       Y,
  input  logic [PIX_W-1:0] cnt,
  output logic [15:0]      err_cnt,
  output logic             err_flag,
  output logic [4:0]       line_idx,
  output logic             busy,
  output logic             frame_done
);

  // LAT holds for SYNC_LAT-1 edges; SYNC_LAT is expected to be at least 2.
  localparam int                LAT_W     = (SYNC_LAT > 2) ? $clog2(SYNC_LAT - 1) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(SYNC_LAT - 2);
  localparam logic [4:0]        LINE_LAST = 5'(LINES - 1);

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic [PIX_W-1:0] expected;
  logic             last_pix;
  logic             mode_valid;
  logic             frame_start;
  logic             short_line;
  logic             pix_check;
  logic             mismatch;
  logic             line_end;
  logic             last_line;
  logic             next_line;

  pattern_expect u_expect (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .line_start  (next_line),
    .pix_adv     (pix_check),
    .mode        (Mode),
    .const_val   (constVal),
    .x           (X),
    .y           (Y),
    .line_lsb    (line_idx[1:0]),
    .expected    (expected),
    .last_pix    (last_pix),
    .mode_valid  (mode_valid)
  );

  // A sync on the last pixel is a normal line end, not a short line.
  assign frame_start = f_sync & sync;
  assign short_line  = sync & ~frame_start & mode_valid &
                       ((state == ST_LAT) | ((state == ST_CHECK) & ~last_pix));
  assign pix_check   = ~frame_start & (state == ST_CHECK) & ~short_line;
  assign mismatch    = pix_check & (cnt != expected);
  assign line_end    = pix_check & last_pix;
  assign last_line   = (line_idx == LINE_LAST);
  assign next_line   = short_line |
                       (~frame_start & sync & (state == ST_GAP)) |
                       (line_end & sync & ~last_line);
  assign busy        = (state != ST_IDLE);

  // Line-timing FSM with registered frame_done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start || next_line) begin
        state   <= ST_LAT;
        lat_cnt <= '0;
      end else begin
        case (state)
          ST_LAT: begin
            if (!mode_valid)            state   <= ST_IDLE;
            else if (lat_cnt == LAT_LAST) state <= ST_CHECK;
            else                        lat_cnt <= lat_cnt + LAT_W'(1);
          end
          ST_CHECK: begin
            if (line_end) begin
              if (last_line) begin
                state      <= ST_IDLE;
                frame_done <= 1'b1;
              end else begin
                state <= ST_GAP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Error counter (saturating), sticky flag and line index.
  always_ff @(posedge clk) begin
    if (!rst_n || frame_start) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
      line_idx <= '0;
    end else begin
      if (next_line) line_idx <= line_idx + 5'd1;
      if (short_line || mismatch) begin
        err_flag <= 1'b1;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/pattern_checker.md
# pattern_checker

Receive-side counterpart of the pattern generator: samples the 12-bit pixel stream on `cnt` and recomputes the expected pixel from the same sync, mode and parameter inputs. It counts mismatches and short lines, and flags frame completion. It sits at the sink end of the test-pattern path and is used as a built-in self-test monitor.

## Interface
Parameters:
- `SYNC_LAT`, 3: number of `clk` edges from the edge that samples `sync` high to the edge that samples pixel 0.
- `LINES`, 24: number of lines per frame.

Ports:
- `clk`  in  1: master clock.
- `rst_n`  in  1: synchronous active-low reset, one clock domain.
- `f_sync`  in  1: first-line sync. Only has effect when `sync` is also high.
- `sync`  in  1: line start.
- `Mode`  in  3: pattern select. 001 REGULAR, 010 CONST, 011 WHITE1x1, 100 BLACK1x1, 101 WHITE2x2, 110 BLACK2x2, 111 RAMP. 000 is invalid.
- `constVal`  in  12: CONST pixel value.
- `X`  in  2: ramp deltaX code. 00→0, 01→1, 10→4, 11→8.
- `Y`  in  2: ramp deltaY code. 00→0, 01→1, 10→16, 11→1290.
- `cnt`  in  12: pixel under test.
- `err_cnt`  out  16: mismatch count, saturates at 16'hFFFF.
- `err_flag`  out  1: sticky, set on any error.
- `line_idx`  out  5: index of the current line within the frame.
- `busy`  out  1: high in every state except IDLE.
- `frame_done`  out  1: one-cycle pulse at the end of a frame.

## Operation
States:
- IDLE
- LAT: counts `SYNC_LAT`-1 cycles.
- CHECK: compares one pixel per cycle.
- GAP: waits for the next `sync`.

Transitions:
- `f_sync & sync` in any state:
  - clears `err_cnt`, `err_flag` and `line_idx`;
  - latches `Mode`, `constVal`, `X` and `Y`;
  - moves to LAT.
- `sync` alone in GAP: increments `line_idx` and moves to LAT.
- `sync` alone in IDLE: ignored.
- `sync` in LAT or CHECK means a short line:
  - `err_cnt` +1 (one event only);
  - sets `err_flag`;
  - `line_idx` +1;
  - restarts in LAT.
- A latched Mode of 000 goes to IDLE at the next edge with no error recorded.
- CHECK, pixel index p running from 0 to LEN-1:
  - LEN is 4096 for REGULAR and 1290 for every other mode.
  - When `cnt` differs from the expected value, `err_cnt` +1 and `err_flag` is set.
  - After p = LEN-1 the block moves to GAP.
  - If `line_idx` = `LINES`-1 at that point, the block instead pulses `frame_done` and goes to IDLE.

Expected value, for line l and pixel p:
- REGULAR: p ^ (p>>1), i.e. Gray code, 12 bits.
- CONST: latched `constVal`.
- WHITE1x1: 12'hFFF if (p+l) is odd, else 0. BLACK1x1 is the inverse.
- WHITE2x2: 12'hFFF if bit 1 of p XOR bit 1 of l is 1, else 0. BLACK2x2 is the inverse.
- RAMP: (l·dY + p·dX) mod 4096. Computed with running accumulators (line base += dY per line, pixel += dX per pixel), with no multiplier.

Arithmetic:
- All pixel arithmetic is 12-bit and wraps.
- `err_cnt` saturates at 16'hFFFF and never wraps.
- Error and pixel counters hold while in GAP and IDLE.

## Timing
- After reset: every output is 0 and the state is IDLE.
- Reset has priority over all inputs.
- Reset asserted mid-line returns the block to IDLE at that same edge. Results from the interrupted line are discarded.
- If `sync` is sampled at edge E0, pixel p is sampled at edge E0+`SYNC_LAT`+p.
- `err_cnt` and `err_flag` reflect pixel p from edge E0+`SYNC_LAT`+p onward, so the error update has no extra latency.
- `frame_done` is high for the cycle following the edge that samples the last pixel of the last line.
- `sync` arriving on the same edge as the last pixel is sampled: that last pixel is still compared and is not counted as a short line; the new line starts in LAT.

## Structure
- `pattern_pkg` holds the shared definitions used by both generator and checker:
  - Mode encodings;
  - line lengths 1290 and 4096;
  - the deltaX and deltaY decode tables;
  - the state enum.
- One sub-module, `pattern_expect`, holds the latched parameters and accumulators and produces the expected pixel.
- `pattern_checker` keeps the FSM, counters and error logic.

## Test plan
- REGULAR frame with correct Gray stream, 24 lines × 4096 pixels → `err_cnt`=0, `frame_done` pulses once, then `busy`=0.
- CONST `constVal`=12'h5A5 with 3 corrupted pixels in line 7 → `err_cnt`=3 and `err_flag`=1 at the end of the frame.
- RAMP with X=10, Y=11; line 2 pixel 3 must be 12'hA20 ((2·1290+12) mod 4096). Forcing 12'hA21 there → `err_cnt`=1.
- WHITE2x2, then BLACK2x2 run with the WHITE stream → every pixel mismatches, so `err_cnt`=24·1290=30960.
- `sync` mid-line at pixel 500 in CB1x1 → `err_cnt` +1, `line_idx` +1, checking restarts at pixel 0.
- Reset asserted at line 10, followed by a new `f_sync & sync` → counters cleared, and a clean frame gives `err_cnt`=0.
